// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension Funct3/Funct7 codes and the
// multiply/divide sequencer state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] S_IDLE_ENC = 2'b00;
    localparam logic [1:0] S_MUL_ENC  = 2'b01;
    localparam logic [1:0] S_DIV_ENC  = 2'b10;
    localparam logic [1:0] S_DONE_ENC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = S_IDLE_ENC,
        S_MUL  = S_MUL_ENC,
        S_DIV  = S_DIV_ENC,
        S_DONE = S_DONE_ENC
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and operand/result bus of the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [2:0]       funct3;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, operand_a, operand_b, funct3,
        input  busy, done, result
    );

    modport slave (
        input  start, operand_a, operand_b, funct3,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit_datapath.sv
// Multiply/divide datapath: operand magnitudes, shift-add multiplier,
// restoring divider, iteration counter, sign fix and the result register.
// Special divide cases are resolved at load by preloading the quotient and
// remainder registers with the architectural result and a zero count, so
// the ordinary finish path publishes them one edge later.
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       funct3,
    output logic             special,
    output logic             count_zero,
    output logic [WIDTH-1:0] result
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]         funct3_r;
    logic               neg_r;
    logic [CNT_W-1:0]   count_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   result_r;

    logic               sign_a_s, sign_b_s, neg_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic               div_zero_s, overflow_s;
    logic [WIDTH-1:0]   spec_quo_s, spec_rem_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH:0]     shifted_s, diff_s;
    logic [WIDTH-1:0]   rem_next_s, quo_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   result_next_s;

    // Two's-complement negation when the sign flag is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Operand signedness, magnitudes, result sign and special-case detection.
    always_comb begin
        sign_a_s = op_a[WIDTH-1] & ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                                    (funct3 == F3_DIV)  || (funct3 == F3_REM));
        sign_b_s = op_b[WIDTH-1] & ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                                    (funct3 == F3_REM));
        mag_a_s  = cond_neg(sign_a_s, op_a);
        mag_b_s  = cond_neg(sign_b_s, op_b);
        // Remainder takes the dividend sign; product and quotient take A xor B.
        if (funct3[2] && funct3[1]) begin
            neg_s = sign_a_s;
        end else begin
            neg_s = sign_a_s ^ sign_b_s;
        end
        div_zero_s = funct3[2] & (op_b == '0);
        overflow_s = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONES);
        special    = div_zero_s | overflow_s;
        if (div_zero_s) begin
            spec_quo_s = ALL_ONES;
            spec_rem_s = op_a;
        end else begin
            spec_quo_s = MIN_NEG;
            spec_rem_s = '0;
        end
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r & {WIDTH{acc_r[0]}}};
        acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
        shifted_s  = {rem_r, opa_r[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, opb_r};
        if (diff_s[WIDTH]) begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end else begin
            rem_next_s = diff_s[WIDTH-1:0];
        end
        quo_next_s = {opa_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end

    // Sign fix and half/quotient/remainder selection for the final result.
    always_comb begin
        if (neg_r) begin
            prod_s = ~acc_r + (2*WIDTH)'(1);
        end else begin
            prod_s = acc_r;
        end
        if (!funct3_r[2]) begin
            if (funct3_r[1:0] == 2'b00) begin
                result_next_s = prod_s[WIDTH-1:0];
            end else begin
                result_next_s = prod_s[2*WIDTH-1:WIDTH];
            end
        end else if (funct3_r[1]) begin
            result_next_s = cond_neg(neg_r, rem_r);
        end else begin
            result_next_s = cond_neg(neg_r, opa_r);
        end
    end

    // Operand capture on accept, one iteration per step, result write on finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_r <= 3'b000;
            neg_r    <= 1'b0;
            count_r  <= '0;
            acc_r    <= '0;
            rem_r    <= '0;
            opa_r    <= '0;
            opb_r    <= '0;
            result_r <= '0;
        end else if (load) begin
            funct3_r <= funct3;
            neg_r    <= special ? 1'b0 : neg_s;
            count_r  <= special ? '0 : CNT_INIT;
            acc_r    <= {{WIDTH{1'b0}}, mag_b_s};
            opb_r    <= funct3[2] ? mag_b_s : mag_a_s;
            opa_r    <= special ? spec_quo_s : mag_a_s;
            rem_r    <= special ? spec_rem_s : '0;
        end else if (step) begin
            count_r <= count_r - CNT_ONE;
            if (!funct3_r[2]) begin
                acc_r <= acc_next_s;
            end else begin
                rem_r <= rem_next_s;
                opa_r <= quo_next_s;
            end
        end else if (finish) begin
            result_r <= result_next_s;
        end
    end

    assign count_zero = (count_r == '0);
    assign result     = result_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sequencer FSM and start/busy/done
// handshake around muldiv_datapath.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          Clk_i,
    input  logic          Rst_i,
    muldiv_unit_if.slave  bus
);
    md_state_t state_r, state_next_s;
    logic      busy_r, done_r, bypass_r;
    logic      accept_s, step_s, finish_s;
    logic      special_s, count_zero_s, bypass_next_s, busy_next_s;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (Clk_i),
        .rst        (Rst_i),
        .load       (accept_s),
        .step       (step_s),
        .finish     (finish_s),
        .op_a       (bus.operand_a),
        .op_b       (bus.operand_b),
        .funct3     (bus.funct3),
        .special    (special_s),
        .count_zero (count_zero_s),
        .result     (bus.result)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    state_next_s = bus.funct3[2] ? S_DIV : S_MUL;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (count_zero_s) begin
                    finish_s     = 1'b1;
                    state_next_s = S_DONE;
                end else begin
                    step_s       = 1'b1;
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
        // A special-case divide passes through S_DIV for one cycle only to
        // publish its precomputed result, so it is never reported busy.
        if (accept_s) begin
            bypass_next_s = special_s;
        end else begin
            bypass_next_s = bypass_r;
        end
        busy_next_s = ((state_next_s == S_MUL) || (state_next_s == S_DIV)) & ~bypass_next_s;
    end

    // State register and registered handshake outputs.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_r  <= S_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            bypass_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= busy_next_s;
            done_r   <= (state_next_s == S_DONE);
            bypass_r <= bypass_next_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .Clk_i (clk),
        .Rst_i (rst),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.funct3    = f3;
        bus.operand_a = a;
        bus.operand_b = b;
    endtask

    // Wait (bounded) for Done_o; lat = edges since the accept edge.
    task automatic wait_done(input int acc_cyc, input logic exp_busy, output int lat, output logic busy_ok);
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && (cyc - acc_cyc) < 100) begin
            if (bus.busy !== exp_busy) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        lat = cyc - acc_cyc;
    endtask

    // Issue one op, scramble inputs after accept, check latency/result/handshake.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   acc_cyc;
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bus.start = 1'b1;
        drive(f3, a, b);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        drive(~f3, ~a, b + 32'd1);
        wait_done(acc_cyc, (exp_lat > 1), lat, busy_ok);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_res"}, bus.result, exp_res);
        check_val({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check_val({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_val({tag, "_res_hold"}, bus.result, exp_res);
    endtask

    initial begin
        int   acc_cyc;
        int   lat;
        logic busy_ok;

        rst       = 1'b1;
        bus.start = 1'b0;
        drive(3'b000, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_res", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("mul_7_m3",  F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("mulh",      F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("mulhsu",    F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("mulhu",     F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("div_m7_2",  F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2",  F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        do_op("divu",      F3_DIVU,   32'hFFFF_FFFE, 32'h0000_0002, 32'h7FFF_FFFF, 33);
        do_op("remu",      F3_REMU,   32'd100,       32'd7,         32'd2,         33);
        do_op("div_by0",   F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("remu_by0",  F3_REMU,   32'd5,         32'd0,         32'd5,         1);
        do_op("div_ovf",   F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",   F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        do_op("divu_by0",  F3_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, 1);

        // Start pulsed mid-MUL with different operands must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        drive(F3_MUL, 32'd6, 32'd7);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        drive(F3_DIV, 32'd9, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        wait_done(acc_cyc, 1'b1, lat, busy_ok);
        check_val("ign_lat", 32'(lat), 32'd33);
        check_val("ign_res", bus.result, 32'd42);
        check_val("ign_busy", 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check_val("ign_idle_busy", 32'(bus.busy), 32'd0);
        check_val("ign_idle_done", 32'(bus.done), 32'd0);

        // Start held through the DONE cycle: second op issues back-to-back.
        @(negedge clk);
        bus.start = 1'b1;
        drive(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        wait_done(acc_cyc, 1'b1, lat, busy_ok);
        check_val("b2b_first_lat", 32'(lat), 32'd33);
        check_val("b2b_first_res", bus.result, 32'hFFFF_FFFE);
        bus.start = 1'b1;
        drive(F3_DIVU, 32'hFFFF_FFFE, 32'd2);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        check_val("b2b_accept_busy", 32'(bus.busy), 32'd1);
        check_val("b2b_accept_done", 32'(bus.done), 32'd0);
        wait_done(acc_cyc, 1'b1, lat, busy_ok);
        check_val("b2b_second_lat", 32'(lat), 32'd33);
        check_val("b2b_second_res", bus.result, 32'h7FFF_FFFF);
        check_val("b2b_second_busy", 32'(busy_ok), 32'd1);

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        bus.start = 1'b1;
        drive(F3_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", 32'(bus.busy), 32'd0);
        check_val("arst_done", 32'(bus.done), 32'd0);
        check_val("arst_res", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("mul_after_rst", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
